// File: rtl/i2c_txn_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_arb_pkg
// Purpose  : Shared types and constants for the I2C transaction arbiter.
//            Holds the arbiter state encoding, the command field widths and
//            the round-robin pointer advance helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Pointer to the requester after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_txn_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_txn_arbiter_if
// Purpose  : Bundles the requester command/response signals and the engine
//            command port of the transaction arbiter.
// Ports    : req_valid/req_wr/req_addr/req_wdata  requester commands
//            req_ready                            one-hot acceptance pulse
//            rsp_valid/rsp_rdata/rsp_err          one-hot response + payload
//            m_start/m_wr/m_addr/m_din/m_abort    engine command port
//            m_done/m_rdata                       engine completion
// Modports : master - the arbiter itself
//            slave  - the environment (requesters and engine)
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_txn_arbiter_if #(
  parameter int NREQ = 4
);
  import i2c_arb_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_wr;
  logic [ADDR_W*NREQ-1:0] req_addr;
  logic [DATA_W*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   m_start;
  logic                   m_wr;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_din;
  logic                   m_abort;
  logic                   m_done;
  logic [DATA_W-1:0]      m_rdata;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, m_done, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           m_start, m_wr, m_addr, m_din, m_abort
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, m_done, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           m_start, m_wr, m_addr, m_din, m_abort
  );

endinterface
`default_nettype wire

// File: rtl/i2c_txn_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Selects the first set bit of
//            req at or above ptr, searching upward with wrap-around.
// Ports    : req    in  NREQ          request vector
//            ptr    in  clog2(NREQ)   highest-priority position
//            grant  out NREQ          one-hot winner (0 when none)
//            idx    out clog2(NREQ)   winner index (0 when none)
//            any    out 1             at least one request set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4
) (
  input  wire logic [NREQ-1:0]         req,
  input  wire logic [$clog2(NREQ)-1:0] ptr,
  output logic      [NREQ-1:0]         grant,
  output logic      [$clog2(NREQ)-1:0] idx,
  output logic                         any
);

  localparam int c_iw = $clog2(NREQ);

  // Walk offsets from farthest to nearest so the nearest set bit at or after
  // ptr is the last one written and therefore wins.
  always_comb begin : p_pick
    logic [c_iw-1:0] k;
    k     = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = c_iw'((int'(ptr) + i) % NREQ);
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = k;
        any      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_txn_arbiter
// Purpose  : Round-robin arbiter sharing one I2C memory transaction engine
//            among NREQ requesters. Accepts one command at a time, issues it
//            to the engine, waits for done (or aborts on watchdog expiry) and
//            returns the response to the granted requester.
// Ports    : clk  in  clock
//            rst  in  synchronous active-high reset
//            bus  i2c_txn_arbiter_if.master (requester + engine signals)
// Params   : NREQ            number of requesters (2..8)
//            TIMEOUT_CYCLES  WAIT cycles before abort (>= 4)
// Revision : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input wire logic           clk,
  input wire logic           rst,
  i2c_txn_arbiter_if.master  bus
);

  localparam int c_iw  = $clog2(NREQ);
  localparam int c_wdw = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_wdw-1:0] c_wd_last = c_wdw'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  logic [c_iw-1:0]     r_rr_ptr;
  logic [c_iw-1:0]     r_grant;
  logic [c_wdw-1:0]    r_wd;
  logic                r_m_start;
  logic                r_m_wr;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_din;
  logic [NREQ-1:0]     r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic [NREQ-1:0]     w_pick_onehot;
  logic [c_iw-1:0]     w_pick_idx;
  logic                w_pick_any;
  logic                w_accept;
  logic                w_timeout;
  logic [NREQ-1:0]     w_grant_onehot;

  logic [ADDR_W-1:0]   w_addr  [NREQ];
  logic [DATA_W-1:0]   w_wdata [NREQ];

  // Unpack the flat per-requester fields so the winner can be indexed.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_pick_onehot),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  // Acceptance is combinational so req_ready pulses in the same cycle the
  // winner is latched; it is held off while reset is applied.
  assign w_accept       = (r_state == IDLE) && w_pick_any && !rst;
  assign w_timeout      = (r_state == WAIT) && (r_wd == c_wd_last);
  assign w_grant_onehot = NREQ'(1) << r_grant;

  assign bus.req_ready = w_accept ? w_pick_onehot : '0;
  // A done arriving on the expiry cycle completes the transaction normally.
  assign bus.m_abort   = w_timeout && !bus.m_done && !rst;
  assign bus.m_start   = r_m_start;
  assign bus.m_wr      = r_m_wr;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_din     = r_m_din;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_wd        <= '0;
      r_m_start   <= 1'b0;
      r_m_wr      <= 1'b0;
      r_m_addr    <= '0;
      r_m_din     <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_m_start   <= 1'b0;
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_m_wr    <= bus.req_wr[w_pick_idx];
            r_m_addr  <= w_addr[w_pick_idx];
            r_m_din   <= w_wdata[w_pick_idx];
            r_grant   <= w_pick_idx;
            r_m_start <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_wd    <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.m_done) begin
            r_rsp_rdata <= r_m_wr ? '0 : bus.m_rdata;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= w_grant_onehot;
            r_state     <= RESP;
          end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= w_grant_onehot;
            r_state     <= RESP;
          end else begin
            // Only advances below the last value, so it can never wrap.
            r_wd <= r_wd + c_wdw'(1);
          end
        end
        RESP: begin
          r_rr_ptr <= c_iw'(rr_next(32'(r_grant), NREQ));
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_txn_arbiter
// Purpose  : Directed self-checking bench for i2c_txn_arbiter. Instance A
//            uses the default watchdog, instance B a 16-cycle watchdog.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_arbiter;
  import i2c_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NREQ(4)) ifa ();
  i2c_txn_arbiter_if #(.NREQ(4)) ifb ();

  i2c_txn_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(1024)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  i2c_txn_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [63:0] outs_a();
    return {29'b0, ifa.req_ready, ifa.rsp_valid, ifa.m_start, ifa.m_abort,
            ifa.m_wr, ifa.m_addr, ifa.m_din, ifa.rsp_rdata, ifa.rsp_err};
  endfunction

  function automatic logic [63:0] outs_b();
    return {29'b0, ifb.req_ready, ifb.rsp_valid, ifb.m_start, ifb.m_abort,
            ifb.m_wr, ifb.m_addr, ifb.m_din, ifb.rsp_rdata, ifb.rsp_err};
  endfunction

  task automatic set_req_a(input int i, input logic wr, input logic [6:0] a, input logic [7:0] d);
    ifa.req_wr[i]         = wr;
    ifa.req_addr[7*i +: 7]  = a;
    ifa.req_wdata[8*i +: 8] = d;
  endtask

  task automatic set_req_b(input int i, input logic wr, input logic [6:0] a, input logic [7:0] d);
    ifb.req_wr[i]         = wr;
    ifb.req_addr[7*i +: 7]  = a;
    ifb.req_wdata[8*i +: 8] = d;
  endtask

  initial begin
    logic [3:0] oh;
    logic [6:0] ea;
    logic [7:0] rd;

    ifa.req_valid = '0; ifa.req_wr = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifa.m_done = 1'b0;  ifa.m_rdata = '0;
    ifb.req_valid = '0; ifb.req_wr = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
    ifb.m_done = 1'b0;  ifb.m_rdata = '0;

    // ---------------- reset state
    tick(); tick();
    chk("reset_outs_a", outs_a(), 64'd0);
    chk("reset_outs_b", outs_b(), 64'd0);

    // ---------------- round robin, all four valid from reset
    for (int i = 0; i < 4; i++) set_req_a(i, 1'b0, 7'(32'h20 + i), 8'h00);
    ifa.req_valid = 4'hF;
    settle();
    chk("rr_ready_in_reset", 64'(ifa.req_ready), 64'd0);
    rst = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      ea = 7'(32'h20 + (k % 4));
      rd = 8'(32'h10 + k);
      chk("rr_ready", 64'(ifa.req_ready), 64'(oh));
      tick();
      chk("rr_issue", 64'({ifa.req_ready, ifa.m_start, ifa.m_addr}), 64'({4'b0, 1'b1, ea}));
      tick();
      tick();
      ifa.m_done = 1'b1; ifa.m_rdata = rd;
      settle();
      chk("rr_no_abort", 64'({ifa.m_abort, ifa.req_ready}), 64'd0);
      tick();
      ifa.m_done = 1'b0;
      if (k == 4) ifa.req_valid = '0;
      settle();
      chk("rr_rsp", 64'({ifa.req_ready, ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err}),
          64'({4'b0, oh, rd, 1'b0}));
      tick();
      settle();
    end

    // ---------------- m_done outside WAIT is ignored
    ifa.m_done = 1'b1; ifa.m_rdata = 8'h99;
    tick();
    ifa.m_done = 1'b0;
    settle();
    chk("done_idle", 64'({ifa.rsp_valid, ifa.m_start}), 64'd0);

    // ---------------- single read, requester 2, 30-cycle engine
    set_req_a(2, 1'b0, 7'h15, 8'h00);
    ifa.req_valid = 4'b0100;
    settle();
    chk("rd_ready", 64'(ifa.req_ready), 64'(4'b0100));
    tick();
    ifa.req_valid = '0;
    settle();
    chk("rd_start", 64'({ifa.m_start, ifa.m_wr, ifa.m_addr}), 64'({1'b1, 1'b0, 7'h15}));
    tick();
    chk("rd_start_1cyc", 64'(ifa.m_start), 64'd0);
    repeat (28) tick();
    ifa.m_done = 1'b1; ifa.m_rdata = 8'hA5;
    settle();
    chk("rd_pre_rsp", 64'(ifa.rsp_valid), 64'd0);
    tick();
    ifa.m_done = 1'b0; ifa.m_rdata = '0;
    settle();
    chk("rd_rsp", 64'({ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err}), 64'({4'b0100, 8'hA5, 1'b0}));
    tick();
    chk("rd_rsp_1cyc", 64'(ifa.rsp_valid), 64'd0);

    // ---------------- write passthrough, requester 1
    set_req_a(1, 1'b1, 7'h7F, 8'h3C);
    ifa.req_valid = 4'b0010;
    settle();
    chk("wr_ready", 64'(ifa.req_ready), 64'(4'b0010));
    tick();
    ifa.req_valid = '0;
    settle();
    chk("wr_cmd", 64'({ifa.m_start, ifa.m_wr, ifa.m_addr, ifa.m_din}),
        64'({1'b1, 1'b1, 7'h7F, 8'h3C}));
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("wr_stable", 64'({ifa.m_wr, ifa.m_addr, ifa.m_din}), 64'({1'b1, 7'h7F, 8'h3C}));
    end
    ifa.m_done = 1'b1; ifa.m_rdata = 8'hEE;
    settle();
    chk("wr_stable_done", 64'({ifa.m_wr, ifa.m_addr, ifa.m_din}), 64'({1'b1, 7'h7F, 8'h3C}));
    tick();
    ifa.m_done = 1'b0;
    settle();
    chk("wr_rsp", 64'({ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err}), 64'({4'b0010, 8'h00, 1'b0}));
    tick();
    chk("wr_hold_idle", 64'({ifa.m_wr, ifa.m_addr, ifa.m_din}), 64'({1'b1, 7'h7F, 8'h3C}));

    // ---------------- reset during WAIT
    set_req_a(3, 1'b0, 7'h33, 8'h00);
    ifa.req_valid = 4'b1000;
    settle();
    chk("rst_pre_ready", 64'(ifa.req_ready), 64'(4'b1000));
    tick();
    ifa.req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_outs_zero", outs_a(), 64'd0);
    ifa.req_valid = 4'hF;
    settle();
    chk("rst_ready_gated", 64'(ifa.req_ready), 64'd0);
    rst = 1'b0;
    settle();
    chk("rst_ptr_req0", 64'(ifa.req_ready), 64'(4'b0001));
    tick();
    ifa.req_valid = '0;
    settle();
    chk("rst_req0_cmd", 64'({ifa.m_start, ifa.m_addr, ifa.rsp_valid}), 64'({1'b1, 7'h20, 4'b0}));
    tick();
    tick();
    ifa.m_done = 1'b1; ifa.m_rdata = 8'h5A;
    tick();
    ifa.m_done = 1'b0;
    settle();
    chk("rst_req0_rsp", 64'({ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err}), 64'({4'b0001, 8'h5A, 1'b0}));
    tick();

    // ---------------- timeout, 16-cycle watchdog, requester 0
    set_req_b(0, 1'b0, 7'h11, 8'h00);
    ifb.req_valid = 4'b0001;
    settle();
    chk("to_ready", 64'(ifb.req_ready), 64'(4'b0001));
    tick();
    ifb.req_valid = '0;
    settle();
    chk("to_start", 64'(ifb.m_start), 64'd1);
    repeat (15) tick();
    chk("to_pre_abort", 64'({ifb.m_abort, ifb.rsp_valid}), 64'd0);
    tick();
    chk("to_abort", 64'({ifb.m_abort, ifb.rsp_valid}), 64'({1'b1, 4'b0000}));
    tick();
    chk("to_rsp", 64'({ifb.m_abort, ifb.rsp_valid, ifb.rsp_rdata, ifb.rsp_err}),
        64'({1'b0, 4'b0001, 8'h00, 1'b1}));
    tick();

    // next requester served normally
    set_req_b(1, 1'b0, 7'h12, 8'h00);
    ifb.req_valid = 4'b0010;
    settle();
    chk("to_next_ready", 64'(ifb.req_ready), 64'(4'b0010));
    tick();
    ifb.req_valid = '0;
    tick();
    tick();
    ifb.m_done = 1'b1; ifb.m_rdata = 8'h77;
    tick();
    ifb.m_done = 1'b0;
    settle();
    chk("to_next_rsp", 64'({ifb.rsp_valid, ifb.rsp_rdata, ifb.rsp_err}), 64'({4'b0010, 8'h77, 1'b0}));
    tick();

    // ---------------- m_done coincident with the expiry cycle
    set_req_b(2, 1'b0, 7'h13, 8'h00);
    ifb.req_valid = 4'b0100;
    settle();
    chk("col_ready", 64'(ifb.req_ready), 64'(4'b0100));
    tick();
    ifb.req_valid = '0;
    repeat (15) tick();
    tick();
    ifb.m_done = 1'b1; ifb.m_rdata = 8'hC3;
    settle();
    chk("col_no_abort", 64'(ifb.m_abort), 64'd0);
    tick();
    ifb.m_done = 1'b0;
    settle();
    chk("col_rsp", 64'({ifb.m_abort, ifb.rsp_valid, ifb.rsp_rdata, ifb.rsp_err}),
        64'({1'b0, 4'b0100, 8'hC3, 1'b0}));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin transaction arbiter that shares the single I2C memory transaction engine among NREQ requesters. Each requester presents a complete command: read/write, 7-bit address and write data. The arbiter serialises these commands, drives the engine's command port, and waits for the engine's done. It then returns read data or an error to the requester that was granted. A watchdog aborts engine transactions that never complete.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 1024, max cycles spent in WAIT before abort (≥4)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NREQ  per-requester command pending; hold until accepted
- req_wr  in  NREQ  1 = write, 0 = read
- req_addr  in  7*NREQ  packed addresses, requester i at [7i+6:7i]
- req_wdata  in  8*NREQ  packed write data, requester i at [8i+7:8i]
- req_ready  out  NREQ  one-hot, one-cycle acceptance pulse
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- m_start  out  1  one-cycle command strobe to engine
- m_wr  out  1  latched command direction
- m_addr  out  7  latched command address
- m_din  out  8  latched write data
- m_abort  out  1  one-cycle abort strobe to engine
- m_done  in  1  engine transaction complete (pulse)
- m_rdata  in  8  engine read data, valid with m_done

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is set, pick the first requester set at or after rr_ptr, searching upward with wrap.
  - Pulse req_ready for the winner in this cycle.
  - Latch the winner's wr/addr/wdata into m_wr/m_addr/m_din, store the grant index, go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- **ISSUE**
  - m_start=1 for exactly this cycle.
  - Clear the watchdog counter, go to WAIT.
- **WAIT**
  - Increment the watchdog every cycle.
  - On m_done: capture m_rdata (captured value is 0 for writes), rsp_err=0, go to RESP.
  - Else if the watchdog reaches TIMEOUT_CYCLES-1: pulse m_abort, captured data=0, rsp_err=1, go to RESP.
  - If m_done and timeout occur in the same cycle, m_done wins and there is no abort.
- **RESP**
  - rsp_valid[grant]=1 for one cycle, with rsp_rdata and rsp_err.
  - rr_ptr = (grant+1) mod NREQ, go to IDLE.
- m_done is ignored outside WAIT.
- m_wr/m_addr/m_din stay stable from ISSUE until the next acceptance.
- A requester deasserting req_valid before acceptance simply drops out of arbitration.
- req_valid of the granted requester is don't-care after acceptance. A new command from that requester is arbitrated again normally.

## Timing
- Reset values:
  - All outputs 0; state IDLE; rr_ptr 0; grant 0; watchdog 0.
  - Reset mid-transaction discards the in-flight command with no response.
- Latency, with acceptance in cycle T:
  - m_start at T+1; watchdog counts from T+2.
  - With m_done at cycle D, rsp_valid at D+1.
  - The earliest next acceptance is D+2.
- Timeout: m_abort at cycle T+1+TIMEOUT_CYCLES if m_done never arrives; rsp_valid follows one cycle later.
- At most one req_ready bit and at most one rsp_valid bit are set in any cycle; they are never set in the same cycle.
- The watchdog is $clog2(TIMEOUT_CYCLES) bits wide and never wraps.
- Fairness: a continuously valid requester is granted within NREQ transactions.

## Structure
- Package i2c_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - localparams ADDR_W=7, DATA_W=8
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any.
  - Reusable by other shared-resource blocks.
- Top module: FSM, command and response registers, watchdog.

## Test plan
- Single read: requester 2, addr 0x15, reset engine model returns 0xA5 after 30 cycles -> req_ready[2] at T, m_start at T+1, rsp_valid[2] with rdata 0xA5, err 0.
- Round robin: all 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; each req_ready only after the previous rsp_valid.
- Write passthrough: requester 1 writes 0x3C to addr 0x7F -> m_wr=1, m_addr=0x7F, m_din=0x3C stable until m_done; rsp_rdata 0.
- Timeout: TIMEOUT_CYCLES=16, engine model never pulses m_done -> m_abort at T+17, rsp_valid with err=1 and rdata 0 at T+18; next requester is served normally.
- Collision and reset: m_done coincident with the timeout cycle -> err=0 and no m_abort. Separately, rst asserted in WAIT -> all outputs 0 the next cycle, no rsp_valid, and rr_ptr=0 so requester 0 wins next.
